// File: rtl/usb_hid_pkg.sv
// -----------------------------------------------------------------------------
// usb_hid_pkg
// Shared types and constants for the HID boot-keyboard event path.
//   hid_evt_t   : one key event, {press, key}
//   kbd_state_t : scan FSM states of hid_kbd_event_decoder
//   is_rollover : true when all six keycode slots report ErrorRollOver
// -----------------------------------------------------------------------------
package usb_hid_pkg;

    typedef struct packed {
        logic       press;
        logic [7:0] key;
    } hid_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOD  = 2'd1,
        ST_REL  = 2'd2,
        ST_PRS  = 2'd3
    } kbd_state_t;

    localparam int         REPORT_W         = 64;
    localparam int         KEY_SLOT_LSB     = 16;   // byte 2 is the first keycode
    localparam int         NUM_KEY_SLOTS    = 6;
    localparam int         NUM_MOD_BITS     = 8;
    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_FIRST_VALID  = 8'h04;
    localparam logic [7:0] MOD_KEY_BASE     = 8'hE0;

    function automatic logic is_rollover(input logic [REPORT_W-1:0] report);
        logic all_err;
        all_err = 1'b1;
        for (int i = 0; i < NUM_KEY_SLOTS; i++) begin
            if (report[KEY_SLOT_LSB + 8*i +: 8] != KEY_ERR_ROLLOVER) begin
                all_err = 1'b0;
            end
        end
        return all_err;
    endfunction

endpackage

// File: rtl/hid_evt_fifo.sv
// -----------------------------------------------------------------------------
// hid_evt_fifo
// Synchronous first-word-fall-through FIFO of hid_evt_t.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data; accepted when not full, or when full and a
//                pop is accepted in the same cycle
//   full       : no free entry (before considering a same-cycle pop)
//   pop        : consume head; ignored while empty
//   empty      : no entry available
//   head       : head entry, forced to zero while empty
// -----------------------------------------------------------------------------
module hid_evt_fifo
    import usb_hid_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  hid_evt_t push_data,
    output logic     full,
    input  logic     pop,
    output logic     empty,
    output hid_evt_t head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    hid_evt_t    mem_reg [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign head = empty ? hid_evt_t'('0) : mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/hid_kbd_event_decoder.sv
// -----------------------------------------------------------------------------
// hid_kbd_event_decoder
// Turns successive HID boot-keyboard reports into discrete press/release
// events by diffing each accepted report against the previous one.
//   clk, rst        : clock, asynchronous active-high reset
//   report_i        : 64-bit boot report (byte0 modifier, byte1 reserved,
//                     bytes 2..7 keycodes)
//   report_valid_i  : one-cycle strobe qualifying report_i
//   evt_valid_o     : event available at FIFO head
//   evt_press_o     : 1 = press, 0 = release
//   evt_key_o       : HID usage (modifier bit b -> 8'hE0+b)
//   evt_ready_i     : consumer accepts head when evt_valid_o && evt_ready_i
//   busy_o          : scan in progress or report pending
//   drop_cnt_o      : saturating count of overwritten pending reports
// Scan order: 8 modifier bits, 6 release slots, 6 press slots; one item per
// cycle, an item that must push while the FIFO is full holds and retries.
// -----------------------------------------------------------------------------
module hid_kbd_event_decoder
    import usb_hid_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           report_i,
    input  logic                  report_valid_i,
    output logic                  evt_valid_o,
    output logic                  evt_press_o,
    output logic [7:0]            evt_key_o,
    input  logic                  evt_ready_i,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    kbd_state_t            state_reg,       state_next;
    logic [2:0]            idx_reg,         idx_next;
    logic [63:0]           cur_report_reg,  cur_report_next;
    logic [63:0]           prev_report_reg, prev_report_next;
    logic                  pend_valid_reg,  pend_valid_next;
    logic [63:0]           pend_report_reg, pend_report_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg,    drop_cnt_next;

    logic [63:0] sel_report;
    logic        push_req;
    hid_evt_t    push_evt;
    logic        push_ok;

    logic     fifo_full;
    logic     fifo_empty;
    hid_evt_t fifo_head;

    // ---------------------------------------------------------------------
    // Slot views and membership tests for the key under examination.
    // ---------------------------------------------------------------------
    logic [NUM_KEY_SLOTS-1:0][7:0] cur_slot;
    logic [NUM_KEY_SLOTS-1:0][7:0] prev_slot;
    logic [NUM_KEY_SLOTS-1:0]      hit_cur;
    logic [NUM_KEY_SLOTS-1:0]      hit_prev;
    logic [2:0]                    slot_idx;
    logic [7:0]                    scan_key;
    logic [7:0]                    cur_mod;
    logic [7:0]                    prev_mod;

    // idx runs to 7 during MOD; clamp so the slot mux never leaves range.
    assign slot_idx = (idx_reg < 3'd6) ? idx_reg : 3'd5;
    assign scan_key = (state_reg == ST_REL) ? prev_slot[slot_idx] : cur_slot[slot_idx];
    assign cur_mod  = cur_report_reg[7:0];
    assign prev_mod = prev_report_reg[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEY_SLOTS; gi++) begin : g_slot
            assign cur_slot[gi]  = cur_report_reg[KEY_SLOT_LSB + 8*gi +: 8];
            assign prev_slot[gi] = prev_report_reg[KEY_SLOT_LSB + 8*gi +: 8];
            assign hit_cur[gi]   = (cur_slot[gi] == scan_key);
            assign hit_prev[gi]  = (prev_slot[gi] == scan_key);
        end
    endgenerate

    // A same-cycle pop always frees room for a push into a full FIFO.
    assign push_ok = !fifo_full || evt_ready_i;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        cur_report_next  = cur_report_reg;
        prev_report_next = prev_report_reg;
        pend_valid_next  = pend_valid_reg;
        pend_report_next = pend_report_reg;
        drop_cnt_next    = drop_cnt_reg;
        sel_report       = pend_valid_reg ? pend_report_reg : report_i;
        push_req         = 1'b0;
        push_evt         = '0;

        case (state_reg)
            ST_IDLE: begin
                if (pend_valid_reg || report_valid_i) begin
                    pend_valid_next = 1'b0;
                    // ErrorRollOver reports are discarded without touching prev.
                    if (!is_rollover(sel_report)) begin
                        cur_report_next = sel_report;
                        state_next      = ST_MOD;
                        idx_next        = 3'd0;
                    end
                end
            end

            ST_MOD: begin
                push_req       = cur_mod[idx_reg] ^ prev_mod[idx_reg];
                push_evt.press = cur_mod[idx_reg];
                push_evt.key   = MOD_KEY_BASE + {5'd0, idx_reg};
                if (!push_req || push_ok) begin
                    if (idx_reg == 3'd7) begin
                        state_next = ST_REL;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            ST_REL: begin
                push_req       = (scan_key >= KEY_FIRST_VALID) && !(|hit_cur);
                push_evt.press = 1'b0;
                push_evt.key   = scan_key;
                if (!push_req || push_ok) begin
                    if (idx_reg == 3'd5) begin
                        state_next = ST_PRS;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            ST_PRS: begin
                push_req       = (scan_key >= KEY_FIRST_VALID) && !(|hit_prev);
                push_evt.press = 1'b1;
                push_evt.key   = scan_key;
                if (!push_req || push_ok) begin
                    if (idx_reg == 3'd5) begin
                        state_next       = ST_IDLE;
                        idx_next         = 3'd0;
                        prev_report_next = cur_report_reg;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                idx_next   = 3'd0;
            end
        endcase

        // A strobe that cannot be latched directly goes to the pending slot.
        // In IDLE the old pending is being consumed, so that is not a drop.
        if (report_valid_i && ((state_reg != ST_IDLE) || pend_valid_reg)) begin
            pend_report_next = report_i;
            pend_valid_next  = 1'b1;
            if ((state_reg != ST_IDLE) && pend_valid_reg &&
                (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_next = drop_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= 3'd0;
            cur_report_reg  <= '0;
            prev_report_reg <= '0;
            pend_valid_reg  <= 1'b0;
            pend_report_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            cur_report_reg  <= cur_report_next;
            prev_report_reg <= prev_report_next;
            pend_valid_reg  <= pend_valid_next;
            pend_report_reg <= pend_report_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------------
    hid_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop       (evt_ready_i),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign evt_valid_o = !fifo_empty;
    assign evt_press_o = fifo_head.press;
    assign evt_key_o   = fifo_head.key;
    assign busy_o      = (state_reg != ST_IDLE) || pend_valid_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_hid_kbd_event_decoder.sv
module tb_hid_kbd_event_decoder;

    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       report_i;
    logic              report_valid_i;
    logic              evt_valid_o;
    logic              evt_press_o;
    logic [7:0]        evt_key_o;
    logic              evt_ready_i;
    logic              busy_o;
    logic [DROP_W-1:0] drop_cnt_o;

    hid_kbd_event_decoder #(
        .FIFO_DEPTH (2),
        .DROP_CNT_W (DROP_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .report_i       (report_i),
        .report_valid_i (report_valid_i),
        .evt_valid_o    (evt_valid_o),
        .evt_press_o    (evt_press_o),
        .evt_key_o      (evt_key_o),
        .evt_ready_i    (evt_ready_i),
        .busy_o         (busy_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Accepted events, as {press, key}, sampled on the falling edge.
    logic [8:0] got_q[$];
    always @(negedge clk) begin
        if (evt_valid_o && evt_ready_i) begin
            got_q.push_back({evt_press_o, evt_key_o});
        end
    end

    typedef struct {
        logic [63:0]     report;
        int              exp_cyc;
        int              n_evt;
        logic [9:0][8:0] evts;
    } vec_t;

    vec_t vecs[16];
    int   nv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rpt(input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1,
                                        input logic [7:0] k2, input logic [7:0] k3,
                                        input logic [7:0] k4, input logic [7:0] k5);
        return {k5, k4, k3, k2, k1, k0, 8'h00, m};
    endfunction

    task automatic add_vec(input logic [63:0] r, input int cyc);
        vecs[nv].report  = r;
        vecs[nv].exp_cyc = cyc;
        vecs[nv].n_evt   = 0;
        vecs[nv].evts    = '0;
        nv++;
    endtask

    task automatic add_evt(input logic [8:0] e);
        vecs[nv-1].evts[vecs[nv-1].n_evt] = e;
        vecs[nv-1].n_evt++;
    endtask

    // Strobe one report, return cycles until busy_o falls (strobe edge counts as 1).
    task automatic send(input logic [63:0] r, output int cyc);
        report_i       = r;
        report_valid_i = 1'b1;
        @(posedge clk); #1;
        report_valid_i = 1'b0;
        cyc = 1;
        while (busy_o && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (busy_o) begin
            n_fail++;
            $display("FAIL %s: busy_o still 1 after %0d cycles, required 0", name, n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_events(input string name, input logic [8:0] exp[$]);
        chk({name, "_count"}, got_q.size(), exp.size());
        for (int j = 0; j < exp.size(); j++) begin
            if (j < got_q.size()) begin
                chk($sformatf("%s_evt%0d", name, j), got_q[j], exp[j]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc;
        logic [8:0] exp_q[$];

        rst            = 1'b1;
        report_i       = '0;
        report_valid_i = 1'b0;
        evt_ready_i    = 1'b1;

        // ---------------- vector table ----------------
        add_vec(rpt(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h104);
        add_vec(rpt(8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h105);
        add_vec(rpt(8'h00, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h004); add_evt(9'h106);
        add_vec(rpt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h005); add_evt(9'h006);
        add_vec(rpt(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h1E1);
        add_vec(rpt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h0E1);
        add_vec(rpt(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h104);
        add_vec(rpt(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 1);
        add_vec(rpt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21); add_evt(9'h004);
        add_vec(rpt(8'hFF, 8'h04, 8'h04, 8'h03, 8'h02, 8'h00, 8'h00), 21);
        for (int b = 0; b < 8; b++) add_evt(9'h1E0 + 9'(b));
        add_evt(9'h104); add_evt(9'h104);
        add_vec(rpt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 21);
        for (int b = 0; b < 8; b++) add_evt(9'h0E0 + 9'(b));
        add_evt(9'h004); add_evt(9'h004);
        add_vec(rpt(8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2A), 21);
        add_evt(9'h1E0); add_evt(9'h1E7); add_evt(9'h12A);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", evt_valid_o, 1'b0);
        chk("rst_evt_press", evt_press_o, 1'b0);
        chk("rst_evt_key",   evt_key_o,   8'h00);
        chk("rst_busy",      busy_o,      1'b0);
        chk("rst_drop_cnt",  drop_cnt_o,  8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < nv; i++) begin
            got_q.delete();
            send(vecs[i].report, cyc);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_count", i), got_q.size(), vecs[i].n_evt);
            for (int j = 0; j < vecs[i].n_evt; j++) begin
                if (j < got_q.size()) begin
                    chk($sformatf("v%0d_evt%0d", i, j), got_q[j], vecs[i].evts[j]);
                end
            end
            $display("vector %0d: report=%016h cycles=%0d events=%0d", i, vecs[i].report, cyc, got_q.size());
        end
        chk("table_drop_cnt", drop_cnt_o, 8'h00);

        // ---------------- reset mid-scan discards everything ----------------
        evt_ready_i    = 1'b0;
        report_i       = rpt(8'h00, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
        report_valid_i = 1'b1;
        @(posedge clk); #1;
        report_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midscan_busy_before", busy_o, 1'b1);
        chk("midscan_valid_before", evt_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("midscan_valid_after_rst", evt_valid_o, 1'b0);
        chk("midscan_busy_after_rst", busy_o, 1'b0);
        chk("midscan_key_after_rst", evt_key_o, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset mid-scan: busy=%0d valid=%0d", busy_o, evt_valid_o);

        // ---------------- backpressure with a 2-entry FIFO ----------------
        got_q.delete();
        report_i       = rpt(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
        report_valid_i = 1'b1;
        @(posedge clk); #1;
        report_valid_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("stall_busy",  busy_o,      1'b1);
        chk("stall_valid", evt_valid_o, 1'b1);
        chk("stall_head",  {evt_press_o, evt_key_o}, 9'h104);
        @(posedge clk); #1;
        chk("stall_head_stable", {evt_press_o, evt_key_o}, 9'h104);
        evt_ready_i = 1'b1;
        wait_idle("stall_drain");
        exp_q = '{9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h109};
        chk_events("stall", exp_q);
        $display("backpressure: drained %0d events", got_q.size());

        // ---------------- pending overwrite / drop counter ----------------
        got_q.delete();
        report_i       = rpt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        report_valid_i = 1'b1;
        @(posedge clk); #1;
        report_i       = rpt(8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("drop_after_2nd", drop_cnt_o, 8'h00);
        report_i       = rpt(8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        report_valid_i = 1'b0;
        chk("drop_after_3rd", drop_cnt_o, 8'h01);
        chk("drop_busy", busy_o, 1'b1);
        wait_idle("drop_drain");
        exp_q = '{9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h009, 9'h10B};
        chk_events("drop", exp_q);
        chk("drop_final", drop_cnt_o, 8'h01);
        $display("pending overwrite: drop_cnt=%0d events=%0d", drop_cnt_o, got_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hid_kbd_event_decoder.md
Name: hid_kbd_event_decoder

Overview:
- Consumes the 64-bit HID boot-keyboard report that the ULPI host controller (usb_host) produces on reg_o/reg_valid_o.
- Diffs each new report against the previously accepted one and emits discrete key press/release events through a small FIFO with a valid/ready handshake.
- Sits directly downstream of usb_host. It is the first stage of the keyboard datapath toward the application logic.

Parameters:
- FIFO_DEPTH, 16, event FIFO entries; power of two, minimum 2.
- DROP_CNT_W, 8, width of the saturating dropped-report counter.

Ports:
- clk  input  1  system clock, the 60 MHz ULPI clock domain.
- rst  input  1  asynchronous, active-high reset.
- report_i  input  64  boot report. Byte k sits at bits [8k+7:8k]. Byte 0 is the modifier, byte 1 is reserved, bytes 2..7 are keycodes.
- report_valid_i  input  1  single-cycle strobe qualifying report_i.
- evt_valid_o  output  1  an event is available at the FIFO head.
- evt_press_o  output  1  1 = press, 0 = release.
- evt_key_o  output  8  HID usage code. Modifier bit b is reported as 8'hE0+b.
- evt_ready_i  input  1  consumer accepts the head event when evt_valid_o && evt_ready_i.
- busy_o  output  1  a scan is in progress or a report is pending.
- drop_cnt_o  output  DROP_CNT_W  saturating count of overwritten pending reports.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: evt_valid_o=0, evt_press_o=0, evt_key_o=0, busy_o=0, drop_cnt_o=0.
  - Internal state: prev_report=0, pending empty, FIFO empty, FSM=IDLE.
  - Reset mid-scan aborts the scan and discards all FIFO contents.
- FSM states: IDLE -> MOD -> REL -> PRS -> IDLE.
  - IDLE: if pending is valid, or report_valid_i=1, latch the report into cur_report (pending has priority and is cleared), then go to MOD.
  - MOD: one cycle per modifier bit, b=0..7. If cur[b] != prev[b], push {cur[b], 8'hE0+b}.
  - REL: one cycle per slot, i=0..5. If prev key k >= 8'h04 and k does not appear in any of the 6 cur slots, push {0,k}.
  - PRS: one cycle per slot, i=0..5. If cur key k >= 8'h04 and k does not appear in any of the 6 prev slots, push {1,k}.
  - At the end of PRS, prev_report <= cur_report, then return to IDLE.
- Event order is fixed: modifiers ascending, then releases in slot order, then presses in slot order.
- Keycodes 8'h00..8'h03 never generate events.
- Duplicate keycodes within one report: each slot is evaluated independently, so duplicates produce duplicate events.
- ErrorRollOver: if all six keycode bytes equal 8'h01, the FSM skips MOD/REL/PRS, goes straight back to IDLE, and leaves prev_report unchanged.
- Timing with no stalls: the scan takes exactly 20 cycles (8+6+6) plus 1 IDLE latch cycle. A pushed event is visible on evt_valid_o the following cycle.
- Backpressure: if the FIFO is full in a cycle that must push, the scan index holds and retries. No event is ever dropped; the scan simply stretches.
- A push and a pop in the same cycle on a full FIFO: the pop frees the slot and the push is accepted that cycle.
- report_valid_i while the FSM is not IDLE, or while IDLE is already consuming pending:
  - the report is stored to the one-deep pending register;
  - if pending was already valid, it is overwritten and drop_cnt_o increments, saturating at all-ones.
- report_valid_i in IDLE with pending empty is latched directly; pending stays empty.
- busy_o = (FSM != IDLE) || pending valid.
- FIFO outputs are registered from storage with first-word fall-through: evt_* reflect the head entry whenever evt_valid_o=1, and hold stable while evt_ready_i=0.

Decomposition:
- Package usb_hid_pkg:
  - typedef hid_evt_t = packed struct {logic press; logic [7:0] key;}.
  - typedef for the FSM state enum.
  - Constants: KEY_ERR_ROLLOVER=8'h01, KEY_FIRST_VALID=8'h04, MOD_KEY_BASE=8'hE0, NUM_KEY_SLOTS=6.
- Sub-module hid_evt_fifo: parameterised synchronous FWFT FIFO of hid_evt_t, with push/full and pop/empty; async active-high rst.

Test Plan:
1. Reset, then report with bytes2..7 = 04,00,00,00,00,00 and modifier 00 -> exactly one event {press=1,key=04}; busy_o drops 21 cycles after the strobe; no further events.
2. Previous report 04,05 held, new report 05,06 -> events in order {0,04}, then {1,06}; key 05 produces no event.
3. Modifier 00->02, then 02->00, with no keys -> {1,E1}, then {0,E1}.
4. All six keycodes 01 after previous 04 held -> no events; the next report of all zeros yields {0,04}, proving prev was retained.
5. evt_ready_i held 0 with FIFO_DEPTH=2, report pressing 04..09 -> FSM stalls with 2 entries queued. Releasing ready drains 04,05,06,07,08,09 in order with none lost.
6. Three report strobes 1 cycle apart while scanning -> drop_cnt_o=1, and only the 1st and 3rd reports are processed.
